// File: rtl/comparator_pkg.sv
// Shared encodings for the multi-cycle magnitude comparator.
// Latency: none (constants and a constant function only).
// Backpressure: not applicable.
package comparator_pkg;

  // FSM state encoding.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    DONE    = 2'd2
  } state_t;

  // One-hot result encoding, ordered {less, equal, greater}.
  localparam logic [2:0] LT   = 3'b100;
  localparam logic [2:0] EQ   = 3'b010;
  localparam logic [2:0] GT   = 3'b001;
  localparam logic [2:0] NONE = 3'b000;

  // Width needed to count 0..num_chunks examined chunks.
  function automatic int cyc_width(input int num_chunks);
    return $clog2(num_chunks + 1);
  endfunction

endpackage

// File: rtl/comparator_multi_cycle_if.sv
// Request/result bundle between a requester and comparator_multi_cycle.
// Latency: none (wires only).
// Backpressure: none; the requester watches Busy_Out/Done_Out, starts are dropped outside IDLE.
interface comparator_multi_cycle_if
  import comparator_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int CHUNK_WIDTH = 8
);
  localparam int NUM_CHUNKS = DATA_WIDTH / CHUNK_WIDTH;
  localparam int CYC_W      = cyc_width(NUM_CHUNKS);

  logic                  Start_In;
  logic                  Signed_Mode_In;
  logic [DATA_WIDTH-1:0] Data_A_In;
  logic [DATA_WIDTH-1:0] Data_B_In;
  logic                  Busy_Out;
  logic                  Done_Out;
  logic                  A_Less_Than_B_Out;
  logic                  A_Equal_To_B_Out;
  logic                  A_Greater_Than_B_Out;
  logic [CYC_W-1:0]      Cycles_Out;

  modport master (
    output Start_In, Signed_Mode_In, Data_A_In, Data_B_In,
    input  Busy_Out, Done_Out, A_Less_Than_B_Out, A_Equal_To_B_Out,
           A_Greater_Than_B_Out, Cycles_Out
  );

  modport slave (
    input  Start_In, Signed_Mode_In, Data_A_In, Data_B_In,
    output Busy_Out, Done_Out, A_Less_Than_B_Out, A_Equal_To_B_Out,
           A_Greater_Than_B_Out, Cycles_Out
  );

endinterface

// File: rtl/comparator_chunk.sv
// Unsigned compare of one chunk pair, optionally flipping both MSBs for a signed top chunk.
// Latency: combinational.
// Backpressure: none.
module comparator_chunk #(
  parameter int CHUNK_WIDTH = 8
) (
  input  logic [CHUNK_WIDTH-1:0] Chunk_A_In,
  input  logic [CHUNK_WIDTH-1:0] Chunk_B_In,
  input  logic                   Invert_Msb_In,
  output logic                   Less_Out,
  output logic                   Equal_Out,
  output logic                   Greater_Out
);

  // Flipping the sign bit maps two's-complement order onto unsigned order.
  localparam logic [CHUNK_WIDTH-1:0] MSB_MASK = CHUNK_WIDTH'(1) << (CHUNK_WIDTH - 1);

  logic [CHUNK_WIDTH-1:0] a_x;
  logic [CHUNK_WIDTH-1:0] b_x;

  // Bias the operands, then do a plain unsigned magnitude compare.
  always_comb begin
    a_x         = Invert_Msb_In ? (Chunk_A_In ^ MSB_MASK) : Chunk_A_In;
    b_x         = Invert_Msb_In ? (Chunk_B_In ^ MSB_MASK) : Chunk_B_In;
    Less_Out    = (a_x < b_x);
    Equal_Out   = (a_x == b_x);
    Greater_Out = (a_x > b_x);
  end

endmodule

// File: rtl/comparator_multi_cycle.sv
// Multi-cycle signed/unsigned magnitude compare, MSB chunk first with early exit on inequality.
// Latency: Done_Out rises k+1 cycles after an accepted start, k = chunks examined (1..NUM_CHUNKS).
// Backpressure: starts are only accepted in IDLE; starts during COMPARE/DONE are dropped.
module comparator_multi_cycle
  import comparator_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int CHUNK_WIDTH = 8
) (
  input  logic                     Clock_In,
  input  logic                     Reset_In,
  comparator_multi_cycle_if.slave  bus
);

  localparam int NUM_CHUNKS = DATA_WIDTH / CHUNK_WIDTH;
  localparam int CYC_W      = cyc_width(NUM_CHUNKS);
  localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

  // Operands must split into whole chunks.
  if (DATA_WIDTH % CHUNK_WIDTH != 0) begin : g_bad_width
    $error("DATA_WIDTH must be a multiple of CHUNK_WIDTH");
  end

  state_t                 state_q;
  logic [DATA_WIDTH-1:0]  a_q;
  logic [DATA_WIDTH-1:0]  b_q;
  logic                   signed_q;
  logic [IDX_W-1:0]       idx_q;
  logic                   busy_q;
  logic                   done_q;
  logic [2:0]             result_q;
  logic [CYC_W-1:0]       cycles_q;

  logic [CHUNK_WIDTH-1:0] chunk_a;
  logic [CHUNK_WIDTH-1:0] chunk_b;
  logic                   top_signed;
  logic                   chunk_lt;
  logic                   chunk_eq;
  logic                   chunk_gt;

  // Select the chunk pair under the index; only the top chunk carries the sign.
  always_comb begin
    chunk_a    = a_q[int'(idx_q) * CHUNK_WIDTH +: CHUNK_WIDTH];
    chunk_b    = b_q[int'(idx_q) * CHUNK_WIDTH +: CHUNK_WIDTH];
    top_signed = signed_q && (idx_q == IDX_W'(NUM_CHUNKS - 1));
  end

  comparator_chunk #(
    .CHUNK_WIDTH (CHUNK_WIDTH)
  ) u_chunk (
    .Chunk_A_In    (chunk_a),
    .Chunk_B_In    (chunk_b),
    .Invert_Msb_In (top_signed),
    .Less_Out      (chunk_lt),
    .Equal_Out     (chunk_eq),
    .Greater_Out   (chunk_gt)
  );

  // Control FSM with operand capture, chunk walk and registered result.
  always_ff @(posedge Clock_In) begin
    if (Reset_In) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      signed_q <= 1'b0;
      idx_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= NONE;
      cycles_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.Start_In) begin
            a_q      <= bus.Data_A_In;
            b_q      <= bus.Data_B_In;
            signed_q <= bus.Signed_Mode_In;
            idx_q    <= IDX_W'(NUM_CHUNKS - 1);
            result_q <= NONE;
            cycles_q <= '0;
            busy_q   <= 1'b1;
            state_q  <= COMPARE;
          end
        end
        COMPARE: begin
          cycles_q <= cycles_q + CYC_W'(1);
          if (chunk_lt) begin
            result_q <= LT;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= DONE;
          end else if (chunk_gt) begin
            result_q <= GT;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= DONE;
          end else if (chunk_eq && (idx_q == '0)) begin
            result_q <= EQ;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= DONE;
          end else begin
            idx_q <= idx_q - IDX_W'(1);
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.Busy_Out             = busy_q;
  assign bus.Done_Out             = done_q;
  assign bus.A_Less_Than_B_Out    = result_q[2];
  assign bus.A_Equal_To_B_Out     = result_q[1];
  assign bus.A_Greater_Than_B_Out = result_q[0];
  assign bus.Cycles_Out           = cycles_q;

endmodule

// File: tb/tb_comparator_multi_cycle.sv
// Directed bench for comparator_multi_cycle at DATA_WIDTH=32, CHUNK_WIDTH=8.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// Expected values are hand-derived from the chunk-by-chunk compare.
module tb_comparator_multi_cycle;

  localparam int DW = 32;
  localparam int CW = 8;

  logic Clock_In;
  logic Reset_In;
  int   total;
  int   bad;

  comparator_multi_cycle_if #(.DATA_WIDTH(DW), .CHUNK_WIDTH(CW)) bus ();

  comparator_multi_cycle #(
    .DATA_WIDTH  (DW),
    .CHUNK_WIDTH (CW)
  ) dut (
    .Clock_In (Clock_In),
    .Reset_In (Reset_In),
    .bus      (bus.slave)
  );

  initial Clock_In = 1'b0;
  always #5 Clock_In = ~Clock_In;

  task automatic tick();
    @(posedge Clock_In);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] flags();
    return {29'd0, bus.A_Less_Than_B_Out, bus.A_Equal_To_B_Out, bus.A_Greater_Than_B_Out};
  endfunction

  // Full output snapshot check: busy, done, {lt,eq,gt}, cycles.
  task automatic check_all(input string tag, input logic busy, input logic done,
                           input logic [2:0] res, input logic [2:0] cyc);
    check({tag, ".busy"},   32'(bus.Busy_Out),   32'(busy));
    check({tag, ".done"},   32'(bus.Done_Out),   32'(done));
    check({tag, ".flags"},  flags(),             32'(res));
    check({tag, ".cycles"}, 32'(bus.Cycles_Out), 32'(cyc));
  endtask

  // Issue one start, then wait (bounded) for Done; report latency in edges after the start edge.
  task automatic run_compare(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                             output bit seen, output int lat);
    bus.Data_A_In      = a;
    bus.Data_B_In      = b;
    bus.Signed_Mode_In = sgn;
    bus.Start_In       = 1'b1;
    tick();
    bus.Start_In = 1'b0;
    seen = 1'b0;
    lat  = 0;
    for (int i = 1; i <= 6 && !seen; i++) begin
      tick();
      if (bus.Done_Out) begin
        seen = 1'b1;
        lat  = i;
      end
    end
  endtask

  bit seen;
  int lat;
  int done_cnt;

  initial begin
    total = 0;
    bad   = 0;
    Reset_In           = 1'b1;
    bus.Start_In       = 1'b0;
    bus.Signed_Mode_In = 1'b0;
    bus.Data_A_In      = '0;
    bus.Data_B_In      = '0;
    tick();
    tick();
    check_all("reset", 1'b0, 1'b0, 3'b000, 3'd0);
    Reset_In = 1'b0;
    tick();
    check_all("idle", 1'b0, 1'b0, 3'b000, 3'd0);

    // Unsigned 0x12345678 vs 0x12345679: three equal chunks, then less.
    bus.Data_A_In      = 32'h12345678;
    bus.Data_B_In      = 32'h12345679;
    bus.Signed_Mode_In = 1'b0;
    bus.Start_In       = 1'b1;
    tick();
    bus.Start_In = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_all($sformatf("lt_busy%0d", i), 1'b1, 1'b0, 3'b000, 3'(i));
      tick();
    end
    check_all("lt_done", 1'b0, 1'b1, 3'b100, 3'd4);
    tick();
    check_all("lt_after", 1'b0, 1'b0, 3'b100, 3'd4);
    // Result held with Start low for 10 cycles.
    for (int i = 0; i < 10; i++) begin
      tick();
      check_all($sformatf("hold%0d", i), 1'b0, 1'b0, 3'b100, 3'd4);
    end

    // 0x80000000 vs 0x7FFFFFFF unsigned: decided on the top chunk.
    run_compare(32'h80000000, 32'h7FFFFFFF, 1'b0, seen, lat);
    check("u_big.seen", 32'(seen), 32'd1);
    check("u_big.lat", 32'(lat), 32'd1);
    check_all("u_big", 1'b0, 1'b1, 3'b001, 3'd1);
    tick();

    // Same operands signed: -2^31 < 2^31-1.
    run_compare(32'h80000000, 32'h7FFFFFFF, 1'b1, seen, lat);
    check("s_big.seen", 32'(seen), 32'd1);
    check("s_big.lat", 32'(lat), 32'd1);
    check_all("s_big", 1'b0, 1'b1, 3'b100, 3'd1);
    tick();

    // Signed -1 vs -2: decided on the bottom chunk.
    run_compare(32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1, seen, lat);
    check("s_neg.seen", 32'(seen), 32'd1);
    check("s_neg.lat", 32'(lat), 32'd4);
    check_all("s_neg", 1'b0, 1'b1, 3'b001, 3'd4);
    tick();

    // Equal operands with a re-pulsed start (different data) during COMPARE.
    bus.Data_A_In      = 32'hDEADBEEF;
    bus.Data_B_In      = 32'hDEADBEEF;
    bus.Signed_Mode_In = 1'b0;
    bus.Start_In       = 1'b1;
    tick();
    bus.Data_A_In = 32'h0;
    bus.Data_B_In = 32'h1;
    done_cnt = 0;
    for (int i = 1; i <= 10; i++) begin
      if (i == 3) bus.Start_In = 1'b0;
      tick();
      if (bus.Done_Out) begin
        done_cnt++;
        if (done_cnt == 1) begin
          check("eq.lat", 32'(i), 32'd4);
          check_all("eq", 1'b0, 1'b1, 3'b010, 3'd4);
        end
      end
    end
    check("eq.done_count", 32'(done_cnt), 32'd1);
    check_all("eq_hold", 1'b0, 1'b0, 3'b010, 3'd4);

    // Start held high through a one-chunk compare: the start seen in DONE is dropped.
    bus.Data_A_In = 32'h80000000;
    bus.Data_B_In = 32'h7FFFFFFF;
    bus.Start_In  = 1'b1;
    tick();
    tick();
    check_all("held_start_done", 1'b0, 1'b1, 3'b001, 3'd1);
    tick();
    check_all("held_start_idle", 1'b0, 1'b0, 3'b001, 3'd1);
    bus.Start_In = 1'b0;
    tick();
    tick();
    tick();

    // Reset in the second COMPARE cycle aborts with no Done pulse.
    bus.Data_A_In = 32'h00000001;
    bus.Data_B_In = 32'h00000002;
    bus.Start_In  = 1'b1;
    tick();
    bus.Start_In = 1'b0;
    tick();
    check_all("abort_pre", 1'b1, 1'b0, 3'b000, 3'd1);
    Reset_In = 1'b1;
    tick();
    Reset_In = 1'b0;
    check_all("abort", 1'b0, 1'b0, 3'b000, 3'd0);
    done_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.Done_Out || bus.Busy_Out) done_cnt++;
    end
    check("abort.no_activity", 32'(done_cnt), 32'd0);

    run_compare(32'h00000001, 32'h00000002, 1'b0, seen, lat);
    check("retry.seen", 32'(seen), 32'd1);
    check("retry.lat", 32'(lat), 32'd4);
    check_all("retry", 1'b0, 1'b1, 3'b100, 3'd4);
    tick();

    // Start and reset together: reset wins, nothing starts.
    Reset_In     = 1'b1;
    bus.Start_In = 1'b1;
    tick();
    Reset_In     = 1'b0;
    bus.Start_In = 1'b0;
    check_all("rst_start", 1'b0, 1'b0, 3'b000, 3'd0);
    tick();
    check_all("rst_start_after", 1'b0, 1'b0, 3'b000, 3'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/comparator_multi_cycle.md
Name: comparator_multi_cycle

Overview:
- Parametrised, multi-cycle magnitude comparator with selectable signed or unsigned mode.
- Compares two DATA_WIDTH operands CHUNK_WIDTH bits per cycle, starting from the MSB chunk, and terminates early on the first unequal chunk.
- Uses a start/busy/done handshake and holds a registered one-hot result, so it fits timing-constrained datapaths where a full-width compare cannot close in one cycle.

Parameters:
- DATA_WIDTH, 32, operand width in bits.
- CHUNK_WIDTH, 8, bits compared per cycle. DATA_WIDTH mod CHUNK_WIDTH must equal 0, otherwise elaboration fails.
- NUM_CHUNKS, DATA_WIDTH/CHUNK_WIDTH, derived localparam, not overridable.

Ports:
- Clock_In  input  1  single clock; all state changes on the rising edge.
- Reset_In  input  1  synchronous, active-high reset.
- Start_In  input  1  request a compare; sampled only in IDLE.
- Signed_Mode_In  input  1  1 = two's-complement compare, 0 = unsigned; latched with Start_In.
- Data_A_In  input  DATA_WIDTH  operand A; latched with Start_In.
- Data_B_In  input  DATA_WIDTH  operand B; latched with Start_In.
- Busy_Out  output  1  high while in COMPARE.
- Done_Out  output  1  one-cycle pulse marking a valid result.
- A_Less_Than_B_Out  output  1  result flag.
- A_Equal_To_B_Out  output  1  result flag.
- A_Greater_Than_B_Out  output  1  result flag.
- Cycles_Out  output  clog2(NUM_CHUNKS+1)  number of chunks examined for the last result.

Behaviour:
- Reset (synchronous, Reset_In high at an edge):
  - State goes to IDLE.
  - Busy_Out, Done_Out, all three flags and Cycles_Out go to 0.
  - Latched operands are cleared.
  - Reset has priority over every other event.
- States: IDLE, COMPARE, DONE.
- IDLE:
  - If Start_In=1, latch A, B and mode; set chunk index to NUM_CHUNKS-1; clear the flags and Cycles_Out to 0; go to COMPARE.
  - If Start_In=0, hold all outputs.
- COMPARE (Busy_Out=1), one chunk per cycle:
  - Increment the chunk counter, so Cycles_Out = chunks examined so far.
  - For the top chunk in signed mode, invert the operand MSBs before the unsigned chunk compare. All other chunks compare unsigned.
  - Chunk A < chunk B: set Less, go to DONE.
  - Chunk A > chunk B: set Greater, go to DONE.
  - Chunks equal and index=0: set Equal, go to DONE.
  - Chunks equal otherwise: decrement index, stay in COMPARE.
- DONE:
  - Done_Out=1 for exactly one cycle, Busy_Out=0, then go to IDLE unconditionally.
  - Start_In is ignored in DONE.
- Latency: Start accepted at edge t gives Done_Out high in the cycle after edge t+k, where k is chunks examined (1..NUM_CHUNKS). Worst case is NUM_CHUNKS+1 cycles from Start to Done.
- Result hold:
  - After DONE, exactly one flag is high and is held, with Cycles_Out, until the next accepted Start.
  - No flag is ever X or Z.
  - All three flags are 0 while Busy_Out=1.
- Start while in COMPARE or DONE is ignored. Input changes after latching do not affect the result in progress.
- Reset mid-COMPARE aborts the compare. Outputs are 0 in the next cycle, and no Done pulse is produced for the aborted operation.
- Start and Reset high together: reset wins and the start is dropped.
- NUM_CHUNKS=1 (CHUNK_WIDTH=DATA_WIDTH): the result always comes after 1 compare cycle, and Cycles_Out=1.

Decomposition:
- Shared package comparator_pkg holds:
  - state encoding constants: IDLE=2'd0, COMPARE=2'd1, DONE=2'd2;
  - result encoding constants: LT=3'b100, EQ=3'b010, GT=3'b001, NONE=3'b000.
- One combinational sub-module, comparator_chunk:
  - parameter CHUNK_WIDTH;
  - inputs: two chunks and Invert_Msb_In;
  - outputs: Less, Equal, Greater.
- The top level owns the FSM, the operand registers, the index counter and the result registers.

Test Plan (DATA_WIDTH=32, CHUNK_WIDTH=8):
- Unsigned, A=0x12345678, B=0x12345679, pulse Start → Busy high 4 cycles, Done pulse in the 5th cycle, Less=1, Cycles_Out=4.
- A=0x80000000, B=0x7FFFFFFF: unsigned → Greater=1, Cycles_Out=1, Done 2 cycles after Start; signed → Less=1, Cycles_Out=1.
- Signed, A=0xFFFFFFFF (-1), B=0xFFFFFFFE (-2) → Greater=1, Cycles_Out=4.
- A=B=0xDEADBEEF, then Start re-pulsed during COMPARE with A=0, B=1 → second Start ignored, Equal=1, Cycles_Out=4, exactly one Done pulse.
- A=0x00000001, B=0x00000002, Reset_In high in the 2nd COMPARE cycle → next cycle all outputs 0, state IDLE, no Done. A following Start with the same operands → Less=1, Cycles_Out=4.
- After any result, hold Start low 10 cycles → flags and Cycles_Out stable, Done stays 0.
